// File: rtl/clk_div_sched_pkg.sv
// clk_div_sched_pkg: shared FSM state type, minimum ratio and DEFAULT_DIV legality check (rev 1.0).
`default_nettype none

package clk_div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int DIV_MIN = 2;

  function automatic bit div_legal(input int div, input int width);
    return (div >= DIV_MIN) && (div < (1 << width));
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_core.sv
// clk_div_core: period counter, terminal detect, registered clk_out/tick (rev 1.0).
// CLK_DIV_SCHED_ODD_DUTY_EN adds a negedge flop that stretches odd-N high time to 50%.
`default_nettype none

module clk_div_core #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] cur_div,   // ratio, run and clear all describe the coming cycle
  input  logic             run,
  input  logic             clear,
  output logic             terminal,
  output logic             tick,
  output logic             clk_out
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_next;
  logic             term_next;
  logic             pos_q;

  assign cnt_next  = (clear || terminal) ? '0 : cnt + DIV_W'(1);
  assign term_next = (cnt_next == cur_div - DIV_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      terminal <= 1'b0;
      tick     <= 1'b0;
      pos_q    <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      terminal <= term_next;
      tick     <= run && term_next;
      pos_q    <= run && (cnt_next < (cur_div >> 1));
    end
  end

`ifdef CLK_DIV_SCHED_ODD_DUTY_EN
  logic odd_q;
  logic neg_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) odd_q <= 1'b0;
    else       odd_q <= cur_div[0];
  end

  // Half-cycle-delayed copy of the high phase; only odd ratios use it.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) neg_q <= 1'b0;
    else       neg_q <= odd_q && pos_q;
  end

  assign clk_out = pos_q | neg_q;
`else
  assign clk_out = pos_q;
`endif

endmodule

`default_nettype wire

// File: rtl/clk_div_sched.sv
// clk_div_sched: divide-by-N controller; ratio changes via valid/ready land on period boundaries (rev 1.0).
// Optional macro CLK_DIV_SCHED_ODD_DUTY_EN gives 50% duty for odd N.
`default_nettype none

module clk_div_sched
  import clk_div_sched_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [DIV_W-1:0] cur_div
);

  if (!div_legal(DEFAULT_DIV, DIV_W)) begin : g_bad_default
    $error("clk_div_sched: DEFAULT_DIV must be >= 2 and < 2**DIV_W");
  end

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] pend_next;
  logic [DIV_W-1:0] div_next;
  logic             err_next;
  logic             run_next;
  logic             terminal;
  logic             xfer;
  logic             legal;

  assign xfer     = cfg_valid && cfg_ready;
  assign legal    = (cfg_div >= DIV_W'(DIV_MIN));
  assign run_next = (state_next != IDLE);

  always_comb begin
    state_next = state;
    div_next   = cur_div;
    pend_next  = pend_div;
    err_next   = xfer && !legal;
    case (state)
      IDLE: begin
        if (xfer && legal) div_next = cfg_div;
        if (enable)        state_next = RUN;
      end
      RUN: begin
        // A stop completing this cycle makes the divider idle, so a new ratio can land directly.
        if (terminal && !enable) begin
          state_next = IDLE;
          if (xfer && legal) div_next = cfg_div;
        end else if (xfer && legal) begin
          pend_next  = cfg_div;
          state_next = PEND;
        end
      end
      PEND: begin
        if (terminal) begin
          div_next   = pend_div;
          state_next = enable ? RUN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_div   <= DIV_W'(DEFAULT_DIV);
      pend_div  <= '0;
      cfg_err   <= 1'b0;
      cfg_ready <= 1'b1;
      running   <= 1'b0;
    end else begin
      state     <= state_next;
      cur_div   <= div_next;
      pend_div  <= pend_next;
      cfg_err   <= err_next;
      cfg_ready <= (state_next != PEND);
      running   <= run_next;
    end
  end

  clk_div_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .cur_div  (div_next),
    .run      (run_next),
    .clear    (state == IDLE),
    .terminal (terminal),
    .tick     (tick),
    .clk_out  (clk_out)
  );

endmodule

`default_nettype wire
